// File: rtl/sys_array_fetcher.sv
// ---------------------------------------------------------------------------
// sys_array_fetcher
//
// Matrix-multiply engine: an operand fetcher/sequencer wrapped around an
// ARRAY_W x ARRAY_W output-stationary systolic array of MAC processing
// elements. Computes C = A * B^T with unsigned operands. Products and sums
// wrap modulo 2^(2*DATA_WIDTH).
//
// Ports:
//   clk          - single clock, rising edge
//   reset_n      - asynchronous active-low reset
//   load_params  - latch input_data_a / input_data_b (only honoured in IDLE)
//   start_comp   - start request, rising-edge detected (only honoured in IDLE)
//   input_data_a - packed [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0], A[i][k]
//   input_data_b - packed [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0], B[j][k]
//   ready        - high while out_data holds a completed result
//   out_data     - packed [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0], C[i][j]
// ---------------------------------------------------------------------------
module sys_array_fetcher #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 5,
  parameter int ARRAY_L    = 2
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     load_params,
  input  logic                                     start_comp,
  input  logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0]    input_data_a,
  input  logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0]    input_data_b,
  output logic                                     ready,
  output logic [ARRAY_W*ARRAY_W*2*DATA_WIDTH-1:0]  out_data
);

  localparam int AccW = 2 * DATA_WIDTH;
  // Last cycle in which a non-zero operand can still reach a PE is TermCnt-1;
  // the extra LastCnt step lets the final accumulation settle before capture.
  localparam int TermCnt = ARRAY_L + 2 * ARRAY_W - 2;
  localparam int LastCnt = TermCnt + 1;
  localparam int CntW    = $clog2(LastCnt + 1);

  typedef enum logic {
    IDLE,
    COMPUTE
  } state_t;

  state_t state_q;
  logic [CntW-1:0] cnt_q;
  logic startPrev_q;
  logic startEdge;
  logic clearPe;

  // Operand memories
  logic [DATA_WIDTH-1:0] opA_q [ARRAY_W][ARRAY_L];
  logic [DATA_WIDTH-1:0] opB_q [ARRAY_W][ARRAY_L];

  // Skewed edge feeds
  logic [DATA_WIDTH-1:0] westFeed  [ARRAY_W];
  logic [DATA_WIDTH-1:0] northFeed [ARRAY_W];

  // PE state and wiring
  logic [DATA_WIDTH-1:0] aPipe_q [ARRAY_W][ARRAY_W];
  logic [DATA_WIDTH-1:0] bPipe_q [ARRAY_W][ARRAY_W];
  logic [AccW-1:0]       accum_q [ARRAY_W][ARRAY_W];
  logic [DATA_WIDTH-1:0] peA     [ARRAY_W][ARRAY_W];
  logic [DATA_WIDTH-1:0] peB     [ARRAY_W][ARRAY_W];
  logic [AccW-1:0]       peProd  [ARRAY_W][ARRAY_W];

  assign startEdge = start_comp && !startPrev_q;
  assign clearPe   = (state_q == IDLE) && startEdge;

  // Row i sees A[i][cnt-i] and column j sees B[j][cnt-j]; the k loop avoids
  // a variable index into the operand memories and yields 0 outside range.
  always_comb begin
    for (int i = 0; i < ARRAY_W; i++) begin
      westFeed[i]  = '0;
      northFeed[i] = '0;
      for (int k = 0; k < ARRAY_L; k++) begin
        if (cnt_q == CntW'(i + k)) begin
          westFeed[i]  = opA_q[i][k];
          northFeed[i] = opB_q[i][k];
        end
      end
    end
  end

  genvar gi, gj;
  for (gi = 0; gi < ARRAY_W; gi++) begin : gRow
    for (gj = 0; gj < ARRAY_W; gj++) begin : gCol
      if (gj == 0) begin : gWest
        assign peA[gi][gj] = westFeed[gi];
      end else begin : gPassA
        assign peA[gi][gj] = aPipe_q[gi][gj-1];
      end
      if (gi == 0) begin : gNorth
        assign peB[gi][gj] = northFeed[gj];
      end else begin : gPassB
        assign peB[gi][gj] = bPipe_q[gi-1][gj];
      end
      assign peProd[gi][gj] = {{DATA_WIDTH{1'b0}}, peA[gi][gj]} *
                              {{DATA_WIDTH{1'b0}}, peB[gi][gj]};
    end
  end

  // PE array: forward a east / b south, accumulate only while computing.
  // Pipeline registers are cleared with the accumulators so nothing stale
  // from an aborted or previous run can leak into a new result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARRAY_W; i++) begin
        for (int j = 0; j < ARRAY_W; j++) begin
          aPipe_q[i][j] <= '0;
          bPipe_q[i][j] <= '0;
          accum_q[i][j] <= '0;
        end
      end
    end else if (clearPe) begin
      for (int i = 0; i < ARRAY_W; i++) begin
        for (int j = 0; j < ARRAY_W; j++) begin
          aPipe_q[i][j] <= '0;
          bPipe_q[i][j] <= '0;
          accum_q[i][j] <= '0;
        end
      end
    end else if (state_q == COMPUTE) begin
      for (int i = 0; i < ARRAY_W; i++) begin
        for (int j = 0; j < ARRAY_W; j++) begin
          aPipe_q[i][j] <= peA[i][j];
          bPipe_q[i][j] <= peB[i][j];
          accum_q[i][j] <= accum_q[i][j] + peProd[i][j];
        end
      end
    end
  end

  // Sequencer FSM with registered ready/out_data and operand capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      startPrev_q <= 1'b0;
      ready       <= 1'b0;
      out_data    <= '0;
      for (int i = 0; i < ARRAY_W; i++) begin
        for (int k = 0; k < ARRAY_L; k++) begin
          opA_q[i][k] <= '0;
          opB_q[i][k] <= '0;
        end
      end
    end else begin
      startPrev_q <= start_comp;
      case (state_q)
        IDLE: begin
          if (load_params) begin
            for (int i = 0; i < ARRAY_W; i++) begin
              for (int k = 0; k < ARRAY_L; k++) begin
                opA_q[i][k] <= input_data_a[((ARRAY_W-1-i)*ARRAY_L + (ARRAY_L-1-k))*DATA_WIDTH +: DATA_WIDTH];
                opB_q[i][k] <= input_data_b[((ARRAY_W-1-i)*ARRAY_L + (ARRAY_L-1-k))*DATA_WIDTH +: DATA_WIDTH];
              end
            end
          end
          if (startEdge) begin
            state_q <= COMPUTE;
            cnt_q   <= '0;
            ready   <= 1'b0;
          end
        end
        COMPUTE: begin
          if (cnt_q == CntW'(LastCnt)) begin
            for (int i = 0; i < ARRAY_W; i++) begin
              for (int j = 0; j < ARRAY_W; j++) begin
                out_data[((ARRAY_W-1-i)*ARRAY_W + (ARRAY_W-1-j))*AccW +: AccW] <= accum_q[i][j];
              end
            end
            ready   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_array_fetcher.sv
// ---------------------------------------------------------------------------
// tb_sys_array_fetcher
//
// Self-checking bench for sys_array_fetcher. Expected results come from a
// behavioural matrix model and are queued when a computation is started,
// then popped and compared when ready rises.
// ---------------------------------------------------------------------------
module tb_sys_array_fetcher;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int L  = 2;
  localparam int RW = 2 * DW;
  localparam int Latency = L + 2 * W;

  typedef logic [W*L*DW-1:0] opVec_t;
  typedef logic [W*W*RW-1:0] resVec_t;

  logic    clk = 1'b0;
  logic    reset_n;
  logic    load_params;
  logic    start_comp;
  opVec_t  input_data_a;
  opVec_t  input_data_b;
  logic    ready;
  resVec_t out_data;

  int passCount  = 0;
  int checkCount = 0;

  resVec_t expQ[$];
  opVec_t  loadedA;
  opVec_t  loadedB;

  sys_array_fetcher #(
    .DATA_WIDTH(DW),
    .ARRAY_W   (W),
    .ARRAY_L   (L)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_params (load_params),
    .start_comp  (start_comp),
    .input_data_a(input_data_a),
    .input_data_b(input_data_b),
    .ready       (ready),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  // Operand builder: mode 0 -> 2i+k+1, mode 1 -> constant val, mode 2 -> random
  function automatic opVec_t makeOp(input int mode, input int val);
    opVec_t v = '0;
    for (int i = 0; i < W; i++) begin
      for (int k = 0; k < L; k++) begin
        logic [DW-1:0] e;
        if (mode == 0)      e = DW'(2 * i + k + 1);
        else if (mode == 1) e = DW'(val);
        else                e = DW'($urandom_range(0, 255));
        v[((W-1-i)*L + (L-1-k))*DW +: DW] = e;
      end
    end
    return v;
  endfunction

  function automatic resVec_t model(input opVec_t a, input opVec_t b);
    resVec_t r = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        logic [RW-1:0] s = '0;
        for (int k = 0; k < L; k++) begin
          s = s + RW'(a[((W-1-i)*L + (L-1-k))*DW +: DW]) * RW'(b[((W-1-j)*L + (L-1-k))*DW +: DW]);
        end
        r[((W-1-i)*W + (W-1-j))*RW +: RW] = s;
      end
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] elemC(input resVec_t r, input int i, input int j);
    return r[((W-1-i)*W + (W-1-j))*RW +: RW];
  endfunction

  function automatic resVec_t allC(input int val);
    resVec_t r = '0;
    for (int n = 0; n < W * W; n++) r[n*RW +: RW] = RW'(val);
    return r;
  endfunction

  // Load operands in IDLE and track what the DUT should now hold
  task automatic doLoad(input opVec_t a, input opVec_t b);
    @(negedge clk);
    input_data_a = a;
    input_data_b = b;
    load_params  = 1'b1;
    @(negedge clk);
    load_params  = 1'b0;
    loadedA = a;
    loadedB = b;
  endtask

  // Raise start at a negedge, queue the expected result, then count cycles
  // from the sampling edge until ready. cycles = -1 when the bound expires.
  task automatic kickStart(input int holdCycles, output int cycles, output logic rdyAtStart);
    @(negedge clk);
    start_comp = 1'b1;
    expQ.push_back(model(loadedA, loadedB));
    cycles = -1;
    @(posedge clk);
    #1;
    rdyAtStart  = ready;
    load_params = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (holdCycles > 0 && n == holdCycles) start_comp = 1'b0;
      if (ready === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      input_data_a = opVec_t'({$urandom(), $urandom(), $urandom()});
      input_data_b = opVec_t'({$urandom(), $urandom(), $urandom()});
      load_params  = 1'($urandom_range(0, 1));
      start_comp   = 1'($urandom_range(0, 1));
    end
    checkCount++;
    if (ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b want 0", ready);
    else passCount++;
    checkCount++;
    if (out_data !== '0) $display("[TB] FAIL reset_out: got %h want 0", out_data);
    else passCount++;
    @(negedge clk);
    load_params = 1'b0;
    start_comp  = 1'b0;
    reset_n     = 1'b1;
    loadedA = '0;
    loadedB = '0;
    repeat (4) @(negedge clk);
    checkCount++;
    if (ready !== 1'b0) $display("[TB] FAIL idle_ready: got %b want 0", ready);
    else passCount++;
    checkCount++;
    if (out_data !== '0) $display("[TB] FAIL idle_out: got %h want 0", out_data);
    else passCount++;
  endtask

  task automatic test_default_matmul;
    int cycles;
    logic r0;
    resVec_t exp;
    doLoad(makeOp(0, 0), makeOp(0, 0));
    kickStart(6, cycles, r0);
    checkCount++;
    if (cycles !== Latency) $display("[TB] FAIL default_latency: got %0d want %0d", cycles, Latency);
    else passCount++;
    checkCount++;
    exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
    if (out_data !== exp) $display("[TB] FAIL default_result: got %h want %h", out_data, exp);
    else passCount++;
    checkCount++;
    if (elemC(out_data, 0, 0) !== 16'd5) $display("[TB] FAIL c00: got %0d want 5", elemC(out_data, 0, 0));
    else passCount++;
    checkCount++;
    if (elemC(out_data, 0, 1) !== 16'd11) $display("[TB] FAIL c01: got %0d want 11", elemC(out_data, 0, 1));
    else passCount++;
    checkCount++;
    if (elemC(out_data, 0, 4) !== 16'd29) $display("[TB] FAIL c04: got %0d want 29", elemC(out_data, 0, 4));
    else passCount++;
    checkCount++;
    if (elemC(out_data, 4, 4) !== 16'd181) $display("[TB] FAIL c44: got %0d want 181", elemC(out_data, 4, 4));
    else passCount++;
  endtask

  task automatic test_back_to_back;
    int cycles;
    logic r0;
    resVec_t exp;
    // Held level through completion must not restart
    doLoad(makeOp(2, 0), makeOp(2, 0));
    kickStart(0, cycles, r0);
    checkCount++;
    if (cycles !== Latency) $display("[TB] FAIL held_latency: got %0d want %0d", cycles, Latency);
    else passCount++;
    exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
    checkCount++;
    if (out_data !== exp) $display("[TB] FAIL held_result: got %h want %h", out_data, exp);
    else passCount++;
    repeat (15) @(negedge clk);
    checkCount++;
    if (ready !== 1'b1) $display("[TB] FAIL held_ready_stable: got %b want 1", ready);
    else passCount++;
    checkCount++;
    if (out_data !== exp) $display("[TB] FAIL held_out_stable: got %h want %h", out_data, exp);
    else passCount++;
    start_comp = 1'b0;
    // Restart with new operands
    doLoad(makeOp(1, 1), makeOp(1, 2));
    kickStart(3, cycles, r0);
    checkCount++;
    if (r0 !== 1'b0) $display("[TB] FAIL restart_ready_drop: got %b want 0", r0);
    else passCount++;
    checkCount++;
    if (cycles !== Latency) $display("[TB] FAIL restart_latency: got %0d want %0d", cycles, Latency);
    else passCount++;
    exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
    checkCount++;
    if (out_data !== allC(4)) $display("[TB] FAIL restart_all4: got %h want %h", out_data, allC(4));
    else passCount++;
    checkCount++;
    if (out_data !== exp) $display("[TB] FAIL restart_model: got %h want %h", out_data, exp);
    else passCount++;
  endtask

  task automatic test_overflow;
    int cycles;
    logic r0;
    resVec_t exp;
    doLoad(makeOp(1, 255), makeOp(1, 255));
    kickStart(2, cycles, r0);
    exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
    checkCount++;
    if (out_data !== allC(64514)) $display("[TB] FAIL overflow: got %h want %h", out_data, allC(64514));
    else passCount++;
    checkCount++;
    if (out_data !== exp) $display("[TB] FAIL overflow_model: got %h want %h", out_data, exp);
    else passCount++;
  endtask

  task automatic test_load_during_compute;
    resVec_t prev;
    resVec_t exp;
    int cycles;
    prev = out_data;
    doLoad(makeOp(2, 0), makeOp(2, 0));
    @(negedge clk);
    start_comp = 1'b1;
    expQ.push_back(model(loadedA, loadedB));
    repeat (4) @(negedge clk);
    start_comp   = 1'b0;
    input_data_a = makeOp(2, 0);
    input_data_b = makeOp(2, 0);
    load_params  = 1'b1;
    @(negedge clk);
    load_params  = 1'b0;
    checkCount++;
    if (out_data !== prev) $display("[TB] FAIL compute_holds_prev: got %h want %h", out_data, prev);
    else passCount++;
    cycles = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        cycles = n;
        break;
      end
    end
    exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
    checkCount++;
    if (cycles < 0 || out_data !== exp) $display("[TB] FAIL load_in_compute: got %h want %h", out_data, exp);
    else passCount++;
    // Load in IDLE after completion leaves the result alone
    doLoad(makeOp(1, 7), makeOp(1, 9));
    repeat (2) @(negedge clk);
    checkCount++;
    if (ready !== 1'b1 || out_data !== exp) $display("[TB] FAIL idle_load_keeps_out: got %b/%h want 1/%h", ready, out_data, exp);
    else passCount++;
  endtask

  task automatic test_reset_mid_compute;
    int cycles;
    logic r0;
    resVec_t exp;
    @(negedge clk);
    start_comp = 1'b1;
    expQ.push_back(model(loadedA, loadedB));
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    expQ.delete();
    checkCount++;
    if (ready !== 1'b0) $display("[TB] FAIL abort_ready: got %b want 0", ready);
    else passCount++;
    checkCount++;
    if (out_data !== '0) $display("[TB] FAIL abort_out: got %h want 0", out_data);
    else passCount++;
    @(negedge clk);
    start_comp = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    loadedA = '0;
    loadedB = '0;
    // Simultaneous load and start: the new operands must be used
    @(negedge clk);
    input_data_a = makeOp(2, 0);
    input_data_b = makeOp(2, 0);
    load_params  = 1'b1;
    loadedA = input_data_a;
    loadedB = input_data_b;
    kickStart(1, cycles, r0);
    checkCount++;
    if (cycles !== Latency) $display("[TB] FAIL post_reset_latency: got %0d want %0d", cycles, Latency);
    else passCount++;
    exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
    checkCount++;
    if (out_data !== exp) $display("[TB] FAIL post_reset_result: got %h want %h", out_data, exp);
    else passCount++;
  endtask

  initial begin
    reset_n      = 1'b0;
    load_params  = 1'b0;
    start_comp   = 1'b0;
    input_data_a = '0;
    input_data_b = '0;
    loadedA      = '0;
    loadedB      = '0;
    test_reset();
    test_default_matmul();
    start_comp = 1'b0;
    test_back_to_back();
    start_comp = 1'b0;
    test_overflow();
    start_comp = 1'b0;
    test_load_during_compute();
    start_comp = 1'b0;
    test_reset_mid_compute();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
